// File: rtl/riscv_cache_maint_ctrl.sv
// Whole-cache maintenance sequencer for one I- or D-cache.
// Latches CPU invalidate/clean requests, waits for the pipeline to drain,
// then walks every set index through the setup stage, one set per
// request/acknowledge handshake. Requests that arrive once the walk has
// started are collected as a pending op and run back-to-back afterwards.
module riscv_cache_maint_ctrl #(
    parameter int XLEN       = 32,
    parameter int SIZE       = 64,
    parameter int BLOCK_SIZE = XLEN,
    parameter int WAYS       = 2,
    // sets = cache bits / (line bits * ways); index width never below one bit
    localparam int SETS      = (SIZE * 32'd1024 * 32'd8) / (BLOCK_SIZE * WAYS),
    localparam int IDX_BITS  = (SETS > 32'd1) ? $clog2(SETS) : 32'd1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                invalidate_i,
    input  logic                clean_i,
    input  logic                pipe_empty_i,
    input  logic                stall_i,
    input  logic                ack_i,
    output logic                busy_o,
    output logic                sel_maint_o,
    output logic                req_o,
    output logic                invalidate_o,
    output logic                clean_o,
    output logic [IDX_BITS-1:0] idx_o,
    output logic                done_o
);

    // Last index is compared explicitly so a non-power-of-2 set count never wraps.
    localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(SETS - 32'd1);
    localparam logic [IDX_BITS-1:0] IDX_ONE  = IDX_BITS'(1'b1);
    localparam logic [IDX_BITS-1:0] IDX_ZERO = {IDX_BITS{1'b0}};

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DRAIN = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t                state_r;
    state_t                state_s;
    logic                  op_inv_r;
    logic                  op_inv_s;
    logic                  op_cln_r;
    logic                  op_cln_s;
    logic                  pend_inv_r;
    logic                  pend_inv_s;
    logic                  pend_cln_r;
    logic                  pend_cln_s;
    logic [IDX_BITS-1:0]   idx_r;
    logic [IDX_BITS-1:0]   idx_s;
    logic                  req_r;
    logic                  done_r;
    logic                  busy_r;
    logic                  new_req_s;

    assign new_req_s = invalidate_i | clean_i;

    // Next-state, op/pending latch and index update for the maintenance walk.
    always_comb begin
        state_s    = state_r;
        op_inv_s   = op_inv_r;
        op_cln_s   = op_cln_r;
        pend_inv_s = pend_inv_r;
        pend_cln_s = pend_cln_r;
        idx_s      = idx_r;
        case (state_r)
            ST_IDLE: begin
                if (new_req_s) begin
                    state_s  = ST_DRAIN;
                    op_inv_s = invalidate_i;
                    op_cln_s = clean_i;
                end else begin
                    state_s  = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                // Walk not started yet: late requests simply widen the current op.
                op_inv_s = op_inv_r | invalidate_i;
                op_cln_s = op_cln_r | clean_i;
                if (pipe_empty_i) begin
                    state_s = ST_ISSUE;
                    idx_s   = IDX_ZERO;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            ST_ISSUE: begin
                pend_inv_s = pend_inv_r | invalidate_i;
                pend_cln_s = pend_cln_r | clean_i;
                if (!stall_i) begin
                    state_s = ST_WAIT;
                end else begin
                    state_s = ST_ISSUE;
                end
            end
            ST_WAIT: begin
                pend_inv_s = pend_inv_r | invalidate_i;
                pend_cln_s = pend_cln_r | clean_i;
                if (ack_i) begin
                    if (idx_r == LAST_IDX) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_ISSUE;
                        idx_s   = idx_r + IDX_ONE;
                    end
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_DONE: begin
                // Pending work (including a request landing this cycle) restarts
                // at DRAIN so busy never drops between the two walks.
                pend_inv_s = 1'b0;
                pend_cln_s = 1'b0;
                if (pend_inv_r | pend_cln_r | new_req_s) begin
                    state_s  = ST_DRAIN;
                    op_inv_s = pend_inv_r | invalidate_i;
                    op_cln_s = pend_cln_r | clean_i;
                end else begin
                    state_s  = ST_IDLE;
                    op_inv_s = 1'b0;
                    op_cln_s = 1'b0;
                end
            end
            default: begin
                state_s    = ST_IDLE;
                op_inv_s   = 1'b0;
                op_cln_s   = 1'b0;
                pend_inv_s = 1'b0;
                pend_cln_s = 1'b0;
                idx_s      = IDX_ZERO;
            end
        endcase
    end

    // State, latches and registered outputs; reset aborts any walk in progress.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r    <= ST_IDLE;
            op_inv_r   <= 1'b0;
            op_cln_r   <= 1'b0;
            pend_inv_r <= 1'b0;
            pend_cln_r <= 1'b0;
            idx_r      <= IDX_ZERO;
            req_r      <= 1'b0;
            done_r     <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            op_inv_r   <= op_inv_s;
            op_cln_r   <= op_cln_s;
            pend_inv_r <= pend_inv_s;
            pend_cln_r <= pend_cln_s;
            idx_r      <= idx_s;
            req_r      <= (state_s == ST_ISSUE) || (state_s == ST_WAIT);
            done_r     <= (state_s == ST_DONE);
            busy_r     <= (state_s != ST_IDLE);
        end
    end

    assign sel_maint_o  = (state_r == ST_ISSUE) || (state_r == ST_WAIT);
    assign busy_o       = busy_r;
    assign req_o        = req_r;
    assign done_o       = done_r;
    assign invalidate_o = op_inv_r;
    assign clean_o      = op_cln_r;
    assign idx_o        = idx_r;

endmodule
